dc_filter_driver: RTL
=====================

# dc_filter_driver

Upstream/downstream companion of the DC_Filter p2p interfaces. The block sits on the other end of the filter's `i_rgb` and `o_result` channels. It transmits host-written 24-bit RGB pixels to the filter through a show-ahead FIFO and receives filtered results into a one-entry holding register. It counts pixels per frame and flags frame completion, so a host or sequencer can stream whole images through the filter.

## Interface
Parameters:
- DEPTH, 4 — TX FIFO entries; power of two, ≥2.
- FRAME_PIX, 65536 — pixels per frame (256×256); ≥1.
- MAX_INFLIGHT, 8 — max pixels sent but not yet returned; used only when the limit feature is compiled in.

Ports:
- i_clk  in  1  — single clock; all logic on its rising edge.
- i_rst  in  1  — synchronous, active-high reset.
- i_px_wr  in  1  — host pixel write strobe.
- i_px_data  in  24  — host pixel {R,G,B}.
- o_px_full  out  1  — TX FIFO full.
- o_rgb_vld  out  1  — pixel valid toward filter.
- o_rgb_data  out  24  — pixel toward filter.
- i_rgb_busy  in  1  — filter cannot accept.
- i_result_vld  in  1  — filter result valid.
- i_result_data  in  24  — filter result.
- o_result_busy  out  1  — driver cannot accept a result.
- o_res_vld  out  1  — result held for host.
- o_res_data  out  24  — held result.
- i_res_rd  in  1  — host pops the held result.
- o_frame_done  out  1  — one-cycle pulse on the last result of a frame.
- o_overflow  out  1  — sticky; set by a write while full.

## Operation
- The p2p transfer rule applies to both channels: a beat completes on a rising edge with vld=1 and busy=0.
- TX FIFO:
  - A write is accepted when i_px_wr=1 and count<DEPTH.
  - A write while full is dropped and sets o_overflow, which clears only on reset.
  - A pop occurs when an rgb beat completes.
  - Push and pop in the same cycle are allowed when not full. Count is unchanged and pointers wrap modulo DEPTH.
- o_rgb_vld = !empty && !limit. o_rgb_data = the FIFO head entry.
- Once o_rgb_vld is high it stays high, with stable data, until the beat completes. The limit can only rise through a completed TX beat, so this holds without extra logic.
- RX register:
  - o_result_busy = res_full, a registered flag.
  - On a completed result beat: capture i_result_data, set res_full.
  - i_res_rd with res_full clears res_full. i_res_rd while empty is ignored.
  - o_res_vld = res_full.
- Counters:
  - tx_cnt increments on each completed TX beat and wraps to 0 after FRAME_PIX-1.
  - rx_cnt does the same for each completed result beat.
  - When a result beat completes with rx_cnt==FRAME_PIX-1, o_frame_done pulses on the next cycle.
  - inflight (width clog2(MAX_INFLIGHT+1), saturates at MAX_INFLIGHT) updates as +1 per TX beat and −1 per RX beat. On a simultaneous TX and RX beat it is unchanged.
  - An RX beat with inflight==0 leaves inflight at 0 (no underflow).

## Timing
- Reset values:
  - Outputs: o_px_full=0, o_rgb_vld=0, o_rgb_data=0, o_result_busy=0, o_res_vld=0, o_res_data=0, o_frame_done=0, o_overflow=0.
  - Internal state: FIFO empty, all counters 0.
- Host write to o_rgb_vld: 1 cycle. A write at edge N gives vld high after edge N.
- Result beat to o_res_vld: 1 cycle. o_result_busy rises in the same cycle.
- Host pop to o_result_busy low: 1 cycle. Sustained result throughput is therefore one beat per 2 cycles.
- TX throughput: one beat per cycle while the filter is not busy and the FIFO is non-empty.
- Reset asserted mid-frame discards FIFO contents, the held result and all counts. In-flight filter results arriving after reset are accepted and counted as the start of a new frame.

## Configuration
- DC_DRIVER_INFLIGHT_LIMIT_EN defined:
  - limit = (inflight==MAX_INFLIGHT).
  - TX stalls until a result returns, which bounds filter occupancy.
- Not defined:
  - limit is tied to 0 and the inflight counter is not built.
  - MAX_INFLIGHT is ignored.
  - TX is limited only by i_rgb_busy.

## Test plan
- Reset, then write 0x112233, 0x445566 with i_rgb_busy=0 → o_rgb_vld high for 2 cycles, data in order, o_px_full never set.
- Hold i_rgb_busy=1 and write 5 pixels with DEPTH=4 → o_px_full=1 after the 4th write; the 5th is dropped and o_overflow=1. Release busy → exactly 4 beats, in order.
- Drive i_result_vld=1 with 0xABCDEF continuously, i_res_rd=0 → one capture, o_result_busy=1 held. Pulse i_res_rd → o_res_vld drops, busy drops next cycle, next result captured.
- FRAME_PIX=4, return 9 results → o_frame_done pulses after the 4th and 8th results only; rx_cnt=1 at end.
- With DC_DRIVER_INFLIGHT_LIMIT_EN and MAX_INFLIGHT=2: write 4 pixels, no results returned → exactly 2 TX beats, then vld low. Return 1 result → one more beat.
- Assert i_rst for 1 cycle with 3 pixels queued and a result held → all outputs at reset values the next cycle, and no stale pixel is transmitted afterwards.

Source files
------------

// File: rtl/dc_filter_driver.sv
// Host-side driver for the DC_Filter p2p channels: show-ahead TX FIFO, one-entry RX holding register,
// frame counting. Define DC_DRIVER_INFLIGHT_LIMIT_EN to bound pixels outstanding in the filter.
module dc_filter_driver #(
    parameter int DEPTH        = 4,
    parameter int FRAME_PIX    = 65536,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_px_wr,
    input  logic [23:0] i_px_data,
    output logic        o_px_full,
    output logic        o_rgb_vld,
    output logic [23:0] o_rgb_data,
    input  logic        i_rgb_busy,
    input  logic        i_result_vld,
    input  logic [23:0] i_result_data,
    output logic        o_result_busy,
    output logic        o_res_vld,
    output logic [23:0] o_res_data,
    input  logic        i_res_rd,
    output logic        o_frame_done,
    output logic        o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_PIX < 1 || MAX_INFLIGHT < 1) begin : g_bad_params
        $error("dc_filter_driver: illegal parameter set");
    end

    logic [23:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          res_full_r;
    logic [23:0]   res_data_r;
    logic [FW-1:0] tx_cnt_r;
    logic [FW-1:0] rx_cnt_r;
    logic          frame_done_r;
    logic          overflow_r;

    logic empty_s;
    logic full_s;
    logic push_s;
    logic tx_beat_s;
    logic rx_beat_s;
    logic limit_s;

    // Channel handshakes and FIFO status decode
    always_comb begin
        empty_s   = (count_r == CW'(0));
        full_s    = (count_r == CW'(DEPTH));
        push_s    = i_px_wr && !full_s;
        tx_beat_s = !empty_s && !limit_s && !i_rgb_busy;
        rx_beat_s = i_result_vld && !res_full_r;
    end

    assign o_px_full     = full_s;
    assign o_rgb_vld     = !empty_s && !limit_s;
    assign o_result_busy = res_full_r;
    assign o_res_vld     = res_full_r;
    assign o_res_data    = res_data_r;
    assign o_frame_done  = frame_done_r;
    assign o_overflow    = overflow_r;

    // Show-ahead head; forced to zero when empty so reset and drained states look identical
    always_comb begin
        if (empty_s) begin
            o_rgb_data = 24'h000000;
        end else begin
            o_rgb_data = mem_r[rd_ptr_r];
        end
    end

    // FIFO storage, no reset needed since the head is masked while empty
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_px_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (tx_beat_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, tx_beat_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (i_px_wr && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // RX holding register and frame counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_full_r   <= 1'b0;
            res_data_r   <= 24'h000000;
            tx_cnt_r     <= '0;
            rx_cnt_r     <= '0;
            frame_done_r <= 1'b0;
        end else begin
            if (rx_beat_s) begin
                res_full_r <= 1'b1;
                res_data_r <= i_result_data;
            end else if (i_res_rd) begin
                res_full_r <= 1'b0;
            end
            if (tx_beat_s) begin
                tx_cnt_r <= (tx_cnt_r == FW'(FRAME_PIX - 1)) ? '0 : tx_cnt_r + FW'(1);
            end
            if (rx_beat_s) begin
                rx_cnt_r <= (rx_cnt_r == FW'(FRAME_PIX - 1)) ? '0 : rx_cnt_r + FW'(1);
            end
            frame_done_r <= rx_beat_s && (rx_cnt_r == FW'(FRAME_PIX - 1));
        end
    end

`ifdef DC_DRIVER_INFLIGHT_LIMIT_EN
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    logic [IW-1:0] inflight_r;

    // Outstanding-pixel tracker; a TX beat can never occur at the limit, so it saturates naturally
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_r <= '0;
        end else if (tx_beat_s && !rx_beat_s && inflight_r != IW'(MAX_INFLIGHT)) begin
            inflight_r <= inflight_r + IW'(1);
        end else if (rx_beat_s && !tx_beat_s && inflight_r != IW'(0)) begin
            inflight_r <= inflight_r - IW'(1);
        end
    end

    assign limit_s = (inflight_r == IW'(MAX_INFLIGHT));
`else
    assign limit_s = 1'b0;
`endif

endmodule
